cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
//  Responder side of the stalling-memory handshake used by fetch and memory stages
//  (Addr/DataIn/Rd/Wr in; DataOut/Done/Stall/CacheHit/err out).
//  Direct-mapped, write-back, write-allocate cache controller.
//  Hits complete in the request cycle; misses stall the requester.
//  During a miss it writes back the victim line and fills from a four-bank backing memory.
// PARAMETERS
//  LINES    256  number of cache lines (power of 2); index = log2(LINES) bits
//  WORDS    4    16-bit words per line (fixed; offset = Addr[2:1])
//  MEM_LAT  2    cycles from accepted mem read to valid mem_rdata
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  Addr           in   16  byte address; Addr[0] must be 0
//  DataIn         in   16  write data
//  Rd             in   1   read request
//  Wr             in   1   write request
//  createdump     in   1   forwarded to mem_createdump
//  DataOut        out  16  read data, valid when Done & Rd
//  Done           out  1   request complete this cycle
//  Stall          out  1   requester must hold Addr/DataIn/Rd/Wr
//  CacheHit       out  1   with Done: 1 = completed without memory traffic
//  err            out  1   illegal request this cycle
//  mem_addr       out  16  backing-memory word address (line base + offset<<1)
//  mem_wdata      out  16  write-back data
//  mem_rd         out  1   backing read request
//  mem_wr         out  1   backing write request
//  mem_stall      in   1   bank busy; current mem request is not accepted, hold it
//  mem_rdata      in   16  fill data, MEM_LAT cycles after an accepted read
//  mem_createdump out  1   dump request to backing memory
// BEHAVIOUR
//  Reset: state=IDLE, all valid/dirty bits cleared.
//   Done=Stall=CacheHit=err=mem_rd=mem_wr=0. DataOut=0. Pending-fill pipe cleared.
//  Reset mid-miss: the request is abandoned and no Done is produced.
//   The backing memory may still complete an in-flight write; that write is harmless.
//  Field split: tag=Addr[15:3+idx], index=Addr[2+idx:3], offset=Addr[2:1].
//  err: (Rd&Wr) or ((Rd|Wr)&Addr[0]) in IDLE.
//   err=1, Done=1, Stall=0 that cycle. No state change and no cache update.
//  Idle with no Rd/Wr: all outputs 0.
//  IDLE hit (valid & tag match):
//   Done=1, CacheHit=1, Stall=0 in the same cycle.
//   Rd: DataOut=word.
//   Wr: word<=DataIn and dirty<=1 at the clock edge.
//  IDLE miss: Stall=1 from this cycle until the Done cycle. Record the victim tag.
//   If the line is valid & dirty, go to WB; otherwise go to FILL.
//  WB: issue 4 mem_wr, words 0..3, at most one per cycle.
//   Advance the word counter only on cycles with ~mem_stall.
//   After the word-3 write is accepted, go to FILL.
//  FILL: issue 4 mem_rd, words 0..3, each advancing only on ~mem_stall.
//   A MEM_LAT-deep shift pipe tags each returning word with its offset.
//   Each returning word is written into the line.
//   On the 4th return: set tag, valid=1, dirty=0, then go to DONE.
//  DONE (1 cycle): Done=1, CacheHit=0, Stall=0.
//   Rd: DataOut=requested word.
//   Wr: merge DataIn into the word, dirty<=1.
//   Next state is IDLE. A new request is sampled no earlier than the next cycle.
//  Requester holds its request stable while Stall=1. A change before Done is unsupported.
//  mem_addr wraps within the line only; there is no carry into the index.
//  createdump is passed through combinationally; it has no effect on the FSM.
// STRUCTURE
//  cache_defs.vh: state encodings (IDLE, WB, FILL, DONE) and the field-width localparams.
//  Sub-module cache_line_array:
//   tag/valid/dirty/data storage.
//   Combinational read; synchronous word write, line-install and clear-on-rst.
//  cache_ctrl holds: FSM, word counters, fill-return pipe, handshake and err logic.
// TESTING
//  1 Cold read Addr=0x0010 -> Stall high; 4 mem_rd at 0x0010..0x0016;
//    then Done=1, CacheHit=0, DataOut=mem[0x0010].
//  2 Repeat read 0x0010 -> Done=1, CacheHit=1 in the same cycle;
//    DataOut unchanged; no mem traffic.
//  3 Write 0x0012=0xBEEF (hit), then read 0x0812 (same index, new tag)
//    -> 4 mem_wr of the old line including 0xBEEF at 0x0012, then 4 mem_rd at 0x0810..0x0816.
//  4 Rd=Wr=1, or Rd=1 with Addr=0x0011 -> err=1, Done=1, Stall=0;
//    no cache or mem change.
//  5 mem_stall=1 for 3 cycles during FILL -> mem_rd/mem_addr held;
//    Done is delayed exactly 3 cycles; data is correct.
//  6 rst during WB -> next cycle IDLE with all lines invalid;
//    a later read of the same address misses.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller slice.
//   - Default geometry (line count, words per line, backing-memory latency).
//   - Bus widths and the word-offset width.
//   - Controller state encoding.
package cache_ctrl_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int WORDS       = 4;
    localparam int OFF_W       = 2;    // log2(WORDS); offset = Addr[2:1]
    localparam int DEF_LINES   = 256;
    localparam int DEF_MEM_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/cache_ctrl_line_array.sv
// Tag / valid / dirty / data storage for a direct-mapped cache.
// All operations address one line, selected by 'index'.
//   clk, rst           clock, synchronous active-high reset (clears valid/dirty)
//   index              line being read or written
//   rd_off             word offset for the combinational word read
//   rd_tag/valid/dirty line status, combinational
//   rd_word            data word at {index, rd_off}, combinational
//   wr_en/off/data     synchronous single-word write
//   wr_dirty           with wr_en: also mark the line dirty
//   inst_en/inst_tag   install line: set tag, valid=1, dirty=0
module cache_ctrl_line_array
    import cache_ctrl_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = ADDR_W - 1 - OFF_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  index,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [DATA_W-1:0] rd_word,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_dirty,
    input  logic              inst_en,
    input  logic [TAG_W-1:0]  inst_tag
);

    logic [TAG_W-1:0]  tags [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [DATA_W-1:0] data [LINES*WORDS];

    assign rd_tag   = tags[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_word  = data[{index, rd_off}];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (inst_en) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (wr_en && wr_dirty) begin
            dirty[index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are not reset; a cleared valid bit makes their
    // contents irrelevant, and leaving them unreset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en)   data[{index, wr_off}] <= wr_data;
        if (inst_en) tags[index]           <= inst_tag;
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller (responder side
// of the stalling-memory handshake). Hits finish in the request cycle; misses
// stall, write back a dirty victim, refill from backing memory, then finish.
//   clk, rst                 clock, synchronous active-high reset
//   Addr, DataIn, Rd, Wr     request (held stable while Stall=1)
//   createdump               forwarded combinationally to mem_createdump
//   DataOut                  read data, valid when Done & Rd
//   Done, Stall, CacheHit    completion / hold / no-memory-traffic flags
//   err                      illegal request (Rd&Wr or odd address)
//   mem_addr, mem_wdata      backing-memory word address and write data
//   mem_rd, mem_wr           backing-memory requests, held while mem_stall
//   mem_stall, mem_rdata     backing-memory busy, fill data after MEM_LAT
//   mem_createdump           dump request to backing memory
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int LINES   = DEF_LINES,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    input  logic              createdump,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_createdump
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;

    assign req_tag = Addr[ADDR_W-1:3+IDX_W];
    assign req_idx = Addr[2+IDX_W:3];
    assign req_off = Addr[2:1];

    state_t           state, state_nx;
    logic [2:0]       cnt, cnt_nx;      // words issued; 4 = all fill reads issued
    logic [1:0]       rcnt;             // fill words returned
    logic [TAG_W-1:0] vtag;             // victim tag captured at the miss
    logic             rec_vtag;

    // Fill-return pipe: one slot per cycle of memory latency, each carrying
    // the offset of the read accepted MEM_LAT cycles earlier.
    logic [MEM_LAT-1:0] pv;
    logic [OFF_W-1:0]   po [MEM_LAT];
    logic               push, ret;
    logic [OFF_W-1:0]   ret_off;

    logic [TAG_W-1:0]  arr_tag;
    logic              arr_valid, arr_dirty;
    logic [DATA_W-1:0] arr_word;
    logic [OFF_W-1:0]  arr_off, wr_off;
    logic              wr_en, wr_dirty, inst_en;
    logic [DATA_W-1:0] wr_data;

    logic hit, req, bad;

    cache_ctrl_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .index    (req_idx),
        .rd_off   (arr_off),
        .rd_tag   (arr_tag),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_word  (arr_word),
        .wr_en    (wr_en),
        .wr_off   (wr_off),
        .wr_data  (wr_data),
        .wr_dirty (wr_dirty),
        .inst_en  (inst_en),
        .inst_tag (req_tag)
    );

    assign hit            = arr_valid && (arr_tag == req_tag);
    assign req            = Rd | Wr;
    assign bad            = (Rd & Wr) | (req & Addr[0]);
    assign push           = mem_rd & ~mem_stall;
    assign ret            = pv[MEM_LAT-1];
    assign ret_off        = po[MEM_LAT-1];
    assign mem_createdump = createdump;

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        DataOut   = '0;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        arr_off   = req_off;
        wr_en     = 1'b0;
        wr_off    = req_off;
        wr_data   = DataIn;
        wr_dirty  = 1'b0;
        inst_en   = 1'b0;
        rec_vtag  = 1'b0;

        // Outputs stay quiet and the array is untouched during reset.
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bad) begin
                        err  = 1'b1;
                        Done = 1'b1;
                    end else if (req) begin
                        if (hit) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            if (Rd) begin
                                DataOut = arr_word;
                            end else begin
                                wr_en    = 1'b1;
                                wr_dirty = 1'b1;
                            end
                        end else begin
                            Stall    = 1'b1;
                            rec_vtag = 1'b1;
                            cnt_nx   = '0;
                            state_nx = (arr_valid && arr_dirty) ? WB : FILL;
                        end
                    end
                end
                WB: begin
                    Stall     = 1'b1;
                    arr_off   = cnt[OFF_W-1:0];
                    mem_wr    = 1'b1;
                    mem_addr  = {vtag, req_idx, cnt[OFF_W-1:0], 1'b0};
                    mem_wdata = arr_word;
                    if (!mem_stall) begin
                        if (cnt == 3'd3) begin
                            cnt_nx   = '0;
                            state_nx = FILL;
                        end else begin
                            cnt_nx = cnt + 3'd1;
                        end
                    end
                end
                FILL: begin
                    Stall = 1'b1;
                    if (cnt != 3'd4) begin
                        mem_rd   = 1'b1;
                        mem_addr = {req_tag, req_idx, cnt[OFF_W-1:0], 1'b0};
                        if (!mem_stall) cnt_nx = cnt + 3'd1;
                    end
                    if (ret) begin
                        wr_en   = 1'b1;
                        wr_off  = ret_off;
                        wr_data = mem_rdata;
                        if (rcnt == 2'd3) begin
                            inst_en  = 1'b1;
                            state_nx = DONE;
                        end
                    end
                end
                DONE: begin
                    Done   = 1'b1;
                    cnt_nx = '0;
                    if (Rd) begin
                        DataOut = arr_word;
                    end else if (Wr) begin
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                    end
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rcnt  <= '0;
            pv    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (ret) rcnt <= rcnt + 2'd1;
            pv[0] <= push;
            for (int i = 1; i < MEM_LAT; i++) pv[i] <= pv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rec_vtag) vtag <= arr_tag;
        po[0] <= cnt[OFF_W-1:0];
        for (int i = 1; i < MEM_LAT; i++) po[i] <= po[i-1];
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl.
// A reference cache model (plain arrays and address arithmetic) predicts each
// request's response and the backing-memory traffic it causes; expectations
// are queued and two monitors compare them against Done and the memory bus.
module tb_cache_ctrl;

    localparam int LINES   = 256;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn;
    logic        Rd, Wr, createdump;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic        mem_stall;
    logic [15:0] mem_rdata;
    logic        mem_createdump;

    always #5 clk = ~clk;

    cache_ctrl #(.LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .Addr           (Addr),
        .DataIn         (DataIn),
        .Rd             (Rd),
        .Wr             (Wr),
        .createdump     (createdump),
        .DataOut        (DataOut),
        .Done           (Done),
        .Stall          (Stall),
        .CacheHit       (CacheHit),
        .err            (err),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_stall      (mem_stall),
        .mem_rdata      (mem_rdata),
        .mem_createdump (mem_createdump)
    );

    // ---------------- backing memory (environment) ----------------
    logic [15:0] mem [32768];
    logic [15:0] rd_s1;

    always @(posedge clk) begin
        rd_s1     <= mem[mem_addr[15:1]];
        mem_rdata <= rd_s1;
        if (mem_wr && !mem_stall) mem[mem_addr[15:1]] <= mem_wdata;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          err;
        bit          hit;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_op_t;

    exp_t    exp_q[$];
    mem_op_t mem_q[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit          r_valid [LINES];
    bit          r_dirty [LINES];
    int          r_tag   [LINES];
    logic [15:0] r_data  [LINES][4];
    logic [15:0] ref_mem [32768];

    function automatic logic [15:0] line_addr(input int tag, input int idx, input int w);
        return 16'(tag * 2048 + idx * 8 + w * 2);
    endfunction

    task automatic model_req(input logic [15:0] a, input logic [15:0] d,
                             input bit rd, input bit wr, output int lat);
        exp_t    e;
        mem_op_t m;
        int      idx, tag, off;
        lat    = 0;
        e.err  = (rd && wr) || ((rd || wr) && a[0]);
        e.rd   = rd;
        e.hit  = 1'b1;
        e.data = '0;
        if (!e.err) begin
            idx = (int'(a) / 8) % LINES;
            tag = int'(a) / 2048;
            off = (int'(a) / 2) % 4;
            if (!(r_valid[idx] && r_tag[idx] == tag)) begin
                e.hit = 1'b0;
                lat   = 4 + MEM_LAT + 1;
                if (r_valid[idx] && r_dirty[idx]) begin
                    lat += 4;
                    for (int w = 0; w < 4; w++) begin
                        m.wr   = 1'b1;
                        m.addr = line_addr(r_tag[idx], idx, w);
                        m.data = r_data[idx][w];
                        mem_q.push_back(m);
                        ref_mem[m.addr[15:1]] = m.data;
                    end
                end
                for (int w = 0; w < 4; w++) begin
                    m.wr   = 1'b0;
                    m.addr = line_addr(tag, idx, w);
                    m.data = '0;
                    mem_q.push_back(m);
                    r_data[idx][w] = ref_mem[m.addr[15:1]];
                end
                r_valid[idx] = 1'b1;
                r_dirty[idx] = 1'b0;
                r_tag[idx]   = tag;
            end
            if (rd) e.data = r_data[idx][off];
            if (wr) begin
                r_data[idx][off] = d;
                r_dirty[idx]     = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    // ---------------- monitors ----------------
    initial begin
        exp_t    e;
        mem_op_t m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (Done) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", {31'b0, Done}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("err", {31'b0, err}, {31'b0, e.err});
                        check("stall_at_done", {31'b0, Stall}, 32'd0);
                        if (!e.err) check("cachehit", {31'b0, CacheHit}, {31'b0, e.hit});
                        if (!e.err && e.rd) check("dataout", {16'b0, DataOut}, {16'b0, e.data});
                    end
                end
                if (mem_rd || mem_wr) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected", {30'b0, mem_wr, mem_rd}, 32'd0);
                    end else begin
                        m = mem_q[0];
                        check("mem_kind", {30'b0, mem_wr, mem_rd}, m.wr ? 32'd2 : 32'd1);
                        check("mem_addr", {16'b0, mem_addr}, {16'b0, m.addr});
                        if (m.wr) check("mem_wdata", {16'b0, mem_wdata}, {16'b0, m.data});
                        if (!mem_stall) void'(mem_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {Done, Stall, CacheHit, err, mem_rd, mem_wr, DataOut},
              {6'b0, 16'h0000});
    endtask

    // Issue one request and wait (bounded) for Done. st_start/st_len script
    // mem_stall relative to the request cycle; rnd randomises it instead.
    task automatic run_req(input logic [15:0] a, input logic [15:0] d,
                           input bit rd, input bit wr,
                           input int st_start, input int st_len, input bit rnd);
        int lat, n;
        bit seen;
        @(posedge clk); #1;
        model_req(a, d, rd, wr, lat);
        Addr = a; DataIn = d; Rd = rd; Wr = wr;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 100) begin
            mem_stall = rnd ? ($urandom_range(0, 2) == 0)
                            : (n >= st_start && n < st_start + st_len);
            @(negedge clk);
            if (Done) begin
                seen = 1'b1;
            end else begin
                check("stall_during_miss", {31'b0, Stall}, 32'd1);
                n++;
                @(posedge clk); #1;
            end
        end
        if (!seen) check("done_timeout", {31'b0, Done}, 32'd1);
        else if (!rnd) check("latency", n, lat + ((lat > 0) ? st_len : 0));
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0; mem_stall = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        mem_op_t     m;
        logic [15:0] a, d;
        bit          rd, wr;

        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < LINES; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
            r_tag[i]   = 0;
        end

        rst = 1'b1; Addr = '0; DataIn = '0; Rd = 1'b0; Wr = 1'b0;
        createdump = 1'b0; mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("idle_after_reset");

        createdump = 1'b1; #1;
        check("createdump_hi", {31'b0, mem_createdump}, 32'd1);
        createdump = 1'b0; #1;
        check("createdump_lo", {31'b0, mem_createdump}, 32'd0);

        // Cold miss, then the same address hits.
        run_req(16'h0010, 16'h0000, 1, 0, 0, 0, 0);
        run_req(16'h0010, 16'h0000, 1, 0, 0, 0, 0);

        // Write hit dirties the line; conflicting read writes it back.
        run_req(16'h0012, 16'hBEEF, 0, 1, 0, 0, 0);
        run_req(16'h0812, 16'h0000, 1, 0, 0, 0, 0);

        // Illegal requests change nothing.
        run_req(16'h0812, 16'h1234, 1, 1, 0, 0, 0);
        run_req(16'h0011, 16'h0000, 1, 0, 0, 0, 0);
        run_req(16'h0813, 16'h5555, 0, 1, 0, 0, 0);
        run_req(16'h0812, 16'h0000, 1, 0, 0, 0, 0);
        run_req(16'h0010, 16'h0000, 1, 0, 0, 0, 0);   // old line written back intact

        // Three stalled cycles during the fill issue phase.
        run_req(16'h0104, 16'h0000, 1, 0, 2, 3, 0);

        // Reset in the middle of a write-back.
        run_req(16'h0028, 16'hA5A5, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++) begin
            m.wr   = 1'b1;
            m.addr = line_addr(r_tag[5], 5, w);
            m.data = r_data[5][w];
            mem_q.push_back(m);
            ref_mem[m.addr[15:1]] = m.data;
        end
        Addr = 16'h0828; Rd = 1'b1;
        @(negedge clk);
        check("wb_stall", {31'b0, Stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("wb_write_issued", {31'b0, mem_wr}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; Rd = 1'b0;
        check_idle("outputs_in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
        end
        check_idle("idle_after_mid_wb_reset");
        check("wb_queue_drained", mem_q.size(), 32'd0);
        run_req(16'h0028, 16'h0000, 1, 0, 0, 0, 0);   // misses: lines invalid
        run_req(16'h0828, 16'h0000, 1, 0, 0, 0, 0);

        // Randomised traffic over a few tags and indices to force conflicts.
        for (int i = 0; i < 200; i++) begin
            a  = line_addr($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
            d  = 16'($urandom);
            rd = $urandom_range(0, 1) == 1;
            wr = !rd;
            if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            run_req(a, d, rd, wr, 0, 0, 1);
        end

        check_idle("idle_at_end");
        check("exp_queue_drained", exp_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
